// File: rtl/phaethon_core_param.sv
// Phaethon integer execution core: fetch/decode/execute of one instruction
// at a time over a req/ack RAM port, with flags, a wait-state watchdog and a
// sticky HALT state.
module phaethon_core_param #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NREG        = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ramIn,
  input  logic              readAck,
  input  logic              writeAck,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [DATA_W-1:0] ramOut,
  output logic              readReq,
  output logic              writeReq,
  output logic [ADDR_W-1:0] ipointer,
  output logic [7:0]        opCode,
  output logic              halted,
  output logic              fault,
  output logic [31:0]       debug
);

  localparam int          RI_W    = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  localparam logic [7:0] OP_MOVRC   = 8'd1;
  localparam logic [7:0] OP_MOVRCA  = 8'd2;
  localparam logic [7:0] OP_MOVRR   = 8'd3;
  localparam logic [7:0] OP_MOVCAR  = 8'd4;
  localparam logic [7:0] OP_MOVRRAC = 8'd5;
  localparam logic [7:0] OP_MOVRACR = 8'd6;
  localparam logic [7:0] OP_MOVRRA  = 8'd7;
  localparam logic [7:0] OP_CMPRR   = 8'd8;
  localparam logic [7:0] OP_CMPRC   = 8'd9;
  localparam logic [7:0] OP_JMPC    = 8'd10;
  localparam logic [7:0] OP_JNEC    = 8'd11;
  localparam logic [7:0] OP_ADDRC   = 8'd12;
  localparam logic [7:0] OP_INCR    = 8'd13;
  localparam logic [7:0] OP_DECR    = 8'd14;
  localparam logic [7:0] OP_ADDRR   = 8'd23;
  localparam logic [7:0] OP_SUBRR   = 8'd24;
  localparam logic [7:0] OP_JEQC    = 8'd25;
  localparam logic [7:0] OP_HALT    = 8'd26;

  // FETCH_REQ is encoded as zero so the debug word reads 0 while in reset.
  typedef enum logic [3:0] {
    FETCH_REQ  = 4'd0,
    FETCH_WAIT = 4'd1,
    DECODE     = 4'd2,
    IMM_WAIT   = 4'd3,
    MEM_REQ    = 4'd4,
    MEM_WAIT   = 4'd5,
    EXEC       = 4'd6,
    HALT       = 4'd7
  } state_t;

  state_t            state, state_n;
  logic [15:0]       timer;
  logic [RI_W-1:0]   ra_q, rb_q, rc_q;
  logic [DATA_W-1:0] a_q, b_q, c_q, imm_q, mdata_q;
  logic [DATA_W-1:0] regs [NREG];
  logic              flag_z, flag_lt, flag_gt;
  logic [ADDR_W-1:0] addr_q, addr_c, mem_addr, ip_next;
  logic [DATA_W-1:0] wdata_q, wdata_c, wr_val, cmp_b;
  logic              req_rd, req_wr, set_halt, set_fault;
  logic              in_wait, timeout, wr_en, do_cmp, jump;

  function automatic logic is_known(input logic [7:0] op);
    return op inside {[8'd1:8'd14], [8'd23:8'd26]};
  endfunction

  function automatic logic is_long(input logic [7:0] op);
    return op inside {OP_MOVRC, OP_MOVRCA, OP_MOVCAR, OP_MOVRRAC, OP_MOVRACR,
                      OP_CMPRC, OP_JMPC, OP_JNEC, OP_ADDRC, OP_JEQC};
  endfunction

  function automatic logic is_ram(input logic [7:0] op);
    return op inside {OP_MOVRCA, OP_MOVCAR, OP_MOVRRAC, OP_MOVRACR, OP_MOVRRA};
  endfunction

  function automatic logic is_write(input logic [7:0] op);
    return op inside {OP_MOVCAR, OP_MOVRACR};
  endfunction

  assign in_wait = (state == FETCH_WAIT) || (state == IMM_WAIT) || (state == MEM_WAIT);
  assign timeout = in_wait && (timer == TO_LAST);

  // Requests are gated by the reset pin so they vanish the instant reset asserts.
  assign readReq    = req_rd & reset;
  assign writeReq   = req_wr & reset;
  assign ramAddress = addr_c;
  assign ramOut     = wdata_c;
  assign debug      = {state, 4'b0, 24'(ipointer)};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH_REQ;
    else        state <= state_n;
  end

  // Next-state, request strobes, and the address/data presented with each request.
  always_comb begin
    state_n   = state;
    req_rd    = 1'b0;
    req_wr    = 1'b0;
    addr_c    = addr_q;
    wdata_c   = wdata_q;
    set_halt  = 1'b0;
    set_fault = 1'b0;
    unique case (state)
      FETCH_REQ: begin
        req_rd  = 1'b1;
        addr_c  = ipointer;
        state_n = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (readAck) state_n = DECODE;
        else if (timeout) begin
          state_n   = HALT;
          set_halt  = 1'b1;
          set_fault = 1'b1;
        end
      end
      DECODE: begin
        if (!is_known(opCode)) begin
          state_n   = HALT;
          set_halt  = 1'b1;
          set_fault = 1'b1;
        end else if (opCode == OP_HALT) begin
          state_n  = HALT;
          set_halt = 1'b1;
        end else if (is_long(opCode)) begin
          req_rd  = 1'b1;
          addr_c  = ipointer + ADDR_W'(4);
          state_n = IMM_WAIT;
        end else if (opCode == OP_MOVRRA) begin
          state_n = MEM_REQ;
        end else begin
          state_n = EXEC;
        end
      end
      IMM_WAIT: begin
        if (readAck) state_n = is_ram(opCode) ? MEM_REQ : EXEC;
        else if (timeout) begin
          state_n   = HALT;
          set_halt  = 1'b1;
          set_fault = 1'b1;
        end
      end
      MEM_REQ: begin
        addr_c = mem_addr;
        if (is_write(opCode)) begin
          req_wr  = 1'b1;
          wdata_c = (opCode == OP_MOVCAR) ? b_q : c_q;
        end else begin
          req_rd = 1'b1;
        end
        state_n = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (is_write(opCode) ? writeAck : readAck) state_n = EXEC;
        else if (timeout) begin
          state_n   = HALT;
          set_halt  = 1'b1;
          set_fault = 1'b1;
        end
      end
      EXEC:    state_n = FETCH_REQ;
      HALT:    state_n = HALT;
      default: state_n = FETCH_REQ;
    endcase
  end

  // Execute-stage results: register write, compare, branch target, memory address.
  always_comb begin
    wr_en  = 1'b0;
    wr_val = a_q;
    do_cmp = 1'b0;
    cmp_b  = b_q;
    jump   = 1'b0;
    case (opCode)
      OP_MOVRC:                         begin wr_en = 1'b1; wr_val = imm_q;       end
      OP_MOVRCA, OP_MOVRRAC, OP_MOVRRA: begin wr_en = 1'b1; wr_val = mdata_q;     end
      OP_MOVRR:                         begin wr_en = 1'b1; wr_val = b_q;         end
      OP_ADDRC:                         begin wr_en = 1'b1; wr_val = a_q + imm_q; end
      OP_INCR:   begin wr_en = 1'b1; wr_val = a_q + DATA_W'(1); end
      OP_DECR:   begin wr_en = 1'b1; wr_val = a_q - DATA_W'(1); end
      OP_ADDRR:  begin wr_en = 1'b1; wr_val = b_q + c_q;        end
      OP_SUBRR:  begin wr_en = 1'b1; wr_val = b_q - c_q;        end
      OP_CMPRR:  do_cmp = 1'b1;
      OP_CMPRC:  begin do_cmp = 1'b1; cmp_b = imm_q; end
      OP_JMPC:   jump = 1'b1;
      OP_JNEC:   jump = !flag_z;
      OP_JEQC:   jump = flag_z;
      default:   ;
    endcase
    ip_next = jump ? ADDR_W'(imm_q)
                   : ipointer + (is_long(opCode) ? ADDR_W'(8) : ADDR_W'(4));
    case (opCode)
      OP_MOVRRAC: mem_addr = ADDR_W'(imm_q) + ADDR_W'(b_q);
      OP_MOVRACR: mem_addr = ADDR_W'(imm_q) + ADDR_W'(a_q);
      OP_MOVRRA:  mem_addr = ADDR_W'(b_q);
      default:    mem_addr = ADDR_W'(imm_q);
    endcase
  end

  // Wait-state watchdog: counts consecutive cycles spent in one wait state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             timer <= '0;
    else if ((state_n != state) || !in_wait) timer <= '0;
    else                                     timer <= timer + 16'd1;
  end

  // Datapath: instruction fields, operands, register file, flags, ipointer, status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      ipointer <= '0;
      opCode   <= '0;
      halted   <= 1'b0;
      fault    <= 1'b0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      imm_q    <= '0;
      mdata_q  <= '0;
      flag_z   <= 1'b0;
      flag_lt  <= 1'b0;
      flag_gt  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      addr_q  <= addr_c;
      wdata_q <= wdata_c;
      if (set_halt)  halted <= 1'b1;
      if (set_fault) fault  <= 1'b1;
      case (state)
        FETCH_WAIT: if (readAck) begin
          opCode <= ramIn[7:0];
          ra_q   <= ramIn[8 +: RI_W];
          rb_q   <= ramIn[16 +: RI_W];
          rc_q   <= ramIn[24 +: RI_W];
        end
        DECODE: begin
          a_q <= regs[ra_q];
          b_q <= regs[rb_q];
          c_q <= regs[rc_q];
        end
        IMM_WAIT: if (readAck) imm_q <= ramIn;
        MEM_WAIT: if (readAck && !is_write(opCode)) mdata_q <= ramIn;
        EXEC: begin
          if (wr_en) regs[ra_q] <= wr_val;
          if (do_cmp) begin
            flag_z  <= (a_q == cmp_b);
            flag_lt <= (a_q < cmp_b);
            flag_gt <= (a_q > cmp_b);
          end
          ipointer <= ip_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_phaethon_core_param.sv
// Directed bench for phaethon_core_param with a one-cycle-latency RAM responder.
module tb_phaethon_core_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ramIn = 32'h0;
  logic        readAck = 1'b0;
  logic        writeAck = 1'b0;
  logic [31:0] ramAddress, ramOut, ipointer, debug;
  logic        readReq, writeReq, halted, fault;
  logic [7:0]  opCode;

  logic [31:0] mem [256];
  logic        pend_rd = 1'b0, pend_wr = 1'b0, rd_en = 1'b1;
  logic [7:0]  pend_ad = 8'h0;
  int          nwr = 0;
  int          checks = 0, errors = 0;

  phaethon_core_param #(.DATA_W(32), .ADDR_W(32), .NREG(4), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .ramIn(ramIn), .readAck(readAck), .writeAck(writeAck),
    .ramAddress(ramAddress), .ramOut(ramOut), .readReq(readReq), .writeReq(writeReq),
    .ipointer(ipointer), .opCode(opCode), .halted(halted), .fault(fault), .debug(debug)
  );

  always #5 clk = ~clk;

  // RAM responder: a request seen in one cycle is acknowledged during the next.
  always @(negedge clk) begin
    readAck  = pend_rd && rd_en;
    ramIn    = pend_rd ? mem[pend_ad] : 32'h0;
    writeAck = pend_wr;
    pend_rd  = readReq;
    pend_ad  = ramAddress[9:2];
    pend_wr  = writeReq;
    if (writeReq) begin
      mem[ramAddress[9:2]] = ramOut;
      nwr++;
    end
  end

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c);
    return {c, b, a, op};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    nwr = 0;
  endtask

  task automatic wait_halt(input int maxc);
    int n;
    n = 0;
    while (!halted && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    checks++; if (readReq !== 1'b0 || writeReq !== 1'b0) begin errors++;
      $display("FAIL reset_req: readReq=%b writeReq=%b required 0 0", readReq, writeReq); end
    checks++; if (ramAddress !== 32'h0 || ramOut !== 32'h0) begin errors++;
      $display("FAIL reset_ram: addr=%h out=%h required 0 0", ramAddress, ramOut); end
    checks++; if (ipointer !== 32'h0 || opCode !== 8'h0 || debug !== 32'h0) begin errors++;
      $display("FAIL reset_ip: ip=%h op=%h debug=%h required 0", ipointer, opCode, debug); end
    checks++; if (halted !== 1'b0 || fault !== 1'b0) begin errors++;
      $display("FAIL reset_status: halted=%b fault=%b required 0 0", halted, fault); end
  endtask

  task automatic test_movrc_halt();
    int seen;
    clear_mem();
    mem[0] = ins(1, 1, 0, 0); mem[1] = 32'h1234; mem[2] = ins(26, 0, 0, 0);
    do_reset();
    repeat (4) @(posedge clk); #1;
    checks++; if (ipointer !== 32'h0 || debug[31:28] !== 4'd6) begin errors++;
      $display("FAIL movrc_cycle4: ip=%h state=%0d required 0 6", ipointer, debug[31:28]); end
    @(posedge clk); #1;
    checks++; if (ipointer !== 32'h8) begin errors++;
      $display("FAIL movrc_cycle5: ip=%h required 8", ipointer); end
    wait_halt(20);
    checks++; if (halted !== 1'b1 || fault !== 1'b0) begin errors++;
      $display("FAIL halt_status: halted=%b fault=%b required 1 0", halted, fault); end
    checks++; if (dut.regs[1] !== 32'h1234) begin errors++;
      $display("FAIL movrc_r1: got %h required 00001234", dut.regs[1]); end
    checks++; if (ipointer !== 32'h8 || opCode !== 8'd26) begin errors++;
      $display("FAIL halt_ip: ip=%h op=%h required 8 1a", ipointer, opCode); end
    seen = 0;
    repeat (4) begin @(negedge clk); if (readReq || writeReq) seen++; end
    checks++; if (seen !== 0) begin errors++;
      $display("FAIL halt_quiet: %0d request cycles, required 0", seen); end
  endtask

  task automatic test_memory();
    clear_mem();
    mem[0] = ins(1, 2, 0, 0);  mem[1] = 32'h5;
    mem[2] = ins(4, 0, 2, 0);  mem[3] = 32'h100;
    mem[4] = ins(1, 0, 0, 0);  mem[5] = 32'h100;
    mem[6] = ins(7, 3, 0, 0);
    mem[7] = ins(6, 0, 0, 2);  mem[8] = 32'h10;
    mem[9] = ins(5, 1, 0, 0);  mem[10] = 32'h10;
    mem[11] = ins(26, 0, 0, 0);
    do_reset();
    wait_halt(80);
    checks++; if (halted !== 1'b1 || fault !== 1'b0 || ipointer !== 32'h2C) begin errors++;
      $display("FAIL mem_end: halted=%b fault=%b ip=%h required 1 0 2c", halted, fault, ipointer); end
    checks++; if (mem[64] !== 32'h5 || mem[68] !== 32'h5) begin errors++;
      $display("FAIL mem_store: [100]=%h [110]=%h required 5 5", mem[64], mem[68]); end
    checks++; if (dut.regs[3] !== 32'h5 || dut.regs[1] !== 32'h5) begin errors++;
      $display("FAIL mem_load: r3=%h r1=%h required 5 5", dut.regs[3], dut.regs[1]); end
    checks++; if (nwr !== 2) begin errors++;
      $display("FAIL mem_wrpulses: got %0d required 2", nwr); end
  endtask

  task automatic test_cmp_jump();
    clear_mem();
    mem[0] = ins(1, 1, 0, 0);  mem[1] = 32'h1234;
    mem[2] = ins(9, 1, 0, 0);  mem[3] = 32'h1234;
    mem[4] = ins(25, 0, 0, 0); mem[5] = 32'h40;
    mem[6] = ins(26, 0, 0, 0); mem[16] = ins(26, 0, 0, 0);
    do_reset();
    wait_halt(60);
    checks++; if (ipointer !== 32'h40) begin errors++;
      $display("FAIL jeq_taken_ip: got %h required 40", ipointer); end
    checks++; if ({dut.flag_gt, dut.flag_lt, dut.flag_z} !== 3'b001) begin errors++;
      $display("FAIL jeq_taken_flags: gt,lt,z=%b required 001", {dut.flag_gt, dut.flag_lt, dut.flag_z}); end

    clear_mem();
    mem[0] = ins(9, 1, 0, 0);  mem[1] = 32'h1234;
    mem[2] = ins(25, 0, 0, 0); mem[3] = 32'h40;
    mem[4] = ins(26, 0, 0, 0); mem[16] = ins(26, 0, 0, 0);
    do_reset();
    wait_halt(60);
    checks++; if (ipointer !== 32'h10) begin errors++;
      $display("FAIL jeq_fall_ip: got %h required 10", ipointer); end
    checks++; if ({dut.flag_gt, dut.flag_lt, dut.flag_z} !== 3'b010) begin errors++;
      $display("FAIL jeq_fall_flags: gt,lt,z=%b required 010", {dut.flag_gt, dut.flag_lt, dut.flag_z}); end

    clear_mem();
    mem[0] = ins(1, 1, 0, 0);  mem[1] = 32'h7;
    mem[2] = ins(1, 2, 0, 0);  mem[3] = 32'h3;
    mem[4] = ins(8, 1, 2, 0);
    mem[5] = ins(11, 0, 0, 0); mem[6] = 32'h80;
    mem[7] = ins(26, 0, 0, 0);
    mem[32] = ins(10, 0, 0, 0); mem[33] = 32'h90;
    mem[34] = ins(26, 0, 0, 0); mem[36] = ins(26, 0, 0, 0);
    do_reset();
    wait_halt(80);
    checks++; if (ipointer !== 32'h90) begin errors++;
      $display("FAIL jne_jmp_ip: got %h required 90", ipointer); end
    checks++; if ({dut.flag_gt, dut.flag_lt, dut.flag_z} !== 3'b100) begin errors++;
      $display("FAIL cmprr_flags: gt,lt,z=%b required 100", {dut.flag_gt, dut.flag_lt, dut.flag_z}); end
  endtask

  task automatic test_arith();
    clear_mem();
    mem[0] = ins(1, 1, 0, 0);   mem[1] = 32'hFFFF_FFFF;
    mem[2] = ins(1, 2, 0, 0);   mem[3] = 32'h2;
    mem[4] = ins(23, 1, 1, 2);
    mem[5] = ins(14, 3, 0, 0);
    mem[6] = ins(13, 5, 0, 0);
    mem[7] = ins(24, 2, 2, 3);
    mem[8] = ins(12, 2, 0, 0);  mem[9] = 32'h10;
    mem[10] = ins(3, 4, 6, 0);
    mem[11] = ins(26, 0, 0, 0);
    do_reset();
    wait_halt(80);
    checks++; if (ipointer !== 32'h2C || fault !== 1'b0) begin errors++;
      $display("FAIL arith_end: ip=%h fault=%b required 2c 0", ipointer, fault); end
    checks++; if (dut.regs[1] !== 32'h2) begin errors++;
      $display("FAIL addrr_wrap_incr: r1=%h required 00000002", dut.regs[1]); end
    checks++; if (dut.regs[3] !== 32'hFFFF_FFFF) begin errors++;
      $display("FAIL decr_zero: r3=%h required ffffffff", dut.regs[3]); end
    checks++; if (dut.regs[2] !== 32'h13 || dut.regs[0] !== 32'h13) begin errors++;
      $display("FAIL subrr_addrc_movrr: r2=%h r0=%h required 13 13", dut.regs[2], dut.regs[0]); end
  endtask

  task automatic test_timeout();
    int seen;
    clear_mem();
    rd_en = 1'b0;
    do_reset();
    repeat (8) @(posedge clk); #1;
    checks++; if (fault !== 1'b0 || debug[31:28] !== 4'd1) begin errors++;
      $display("FAIL timeout_early: fault=%b state=%0d required 0 1", fault, debug[31:28]); end
    @(posedge clk); #1;
    checks++; if (fault !== 1'b1 || halted !== 1'b1 || ipointer !== 32'h0) begin errors++;
      $display("FAIL timeout_fault: fault=%b halted=%b ip=%h required 1 1 0", fault, halted, ipointer); end
    seen = 0;
    repeat (4) begin @(negedge clk); if (readReq) seen++; end
    checks++; if (seen !== 0) begin errors++;
      $display("FAIL timeout_quiet: %0d readReq cycles, required 0", seen); end
    rd_en = 1'b1;
  endtask

  task automatic test_bad_opcode();
    clear_mem();
    mem[0] = ins(1, 1, 0, 0); mem[1] = 32'h55; mem[2] = 32'h7F;
    do_reset();
    wait_halt(40);
    checks++; if (fault !== 1'b1 || halted !== 1'b1 || opCode !== 8'h7F) begin errors++;
      $display("FAIL badop_status: fault=%b halted=%b op=%h required 1 1 7f", fault, halted, opCode); end
    checks++; if (ipointer !== 32'h8 || dut.regs[1] !== 32'h55) begin errors++;
      $display("FAIL badop_state: ip=%h r1=%h required 8 55", ipointer, dut.regs[1]); end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_mem();
    mem[0] = ins(7, 3, 0, 0); mem[1] = ins(26, 0, 0, 0);
    do_reset();
    n = 0;
    while (debug[31:28] !== 4'd4 && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (debug[31:28] !== 4'd4 || readReq !== 1'b1) begin errors++;
      $display("FAIL midrst_memreq: state=%0d readReq=%b required 4 1", debug[31:28], readReq); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (readReq !== 1'b0 || writeReq !== 1'b0 || ramAddress !== 32'h0 ||
                  ipointer !== 32'h0 || debug !== 32'h0 || opCode !== 8'h0) begin errors++;
      $display("FAIL midrst_outputs: rr=%b wr=%b addr=%h ip=%h dbg=%h op=%h required all 0",
               readReq, writeReq, ramAddress, ipointer, debug, opCode); end
    @(posedge clk); #1;
    checks++; if (debug !== 32'h0 || dut.regs[3] !== 32'h0) begin errors++;
      $display("FAIL midrst_ackignored: dbg=%h r3=%h required 0 0", debug, dut.regs[3]); end
    reset = 1'b1;
    #1;
    checks++; if (readReq !== 1'b1 || ramAddress !== 32'h0) begin errors++;
      $display("FAIL midrst_refetch: readReq=%b addr=%h required 1 0", readReq, ramAddress); end
    wait_halt(40);
    checks++; if (dut.regs[3] !== 32'h0000_0307 || ipointer !== 32'h4 || fault !== 1'b0) begin errors++;
      $display("FAIL midrst_rerun: r3=%h ip=%h fault=%b required 307 4 0", dut.regs[3], ipointer, fault); end
  endtask

  initial begin
    test_reset();
    test_movrc_halt();
    test_memory();
    test_cmp_jump();
    test_arith();
    test_timeout();
    test_bad_opcode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
